ram_burst_reader: RTL
=====================

# ram_burst_reader

Sequential read-side controller for the equalizer's asynchronous-read RAM (coefficient/sample store, 279 × 16-bit by default). On a start command it walks a contiguous address range, samples the RAM's combinational read data and presents each word on a registered valid/ready output stream with a last-beat marker. It sits between the RAM instance and the filter MAC datapath, which consumes one coefficient or sample per accepted beat.

## Interface
- RAM_HEIGHT, 279, number of RAM words; legal addresses 0..RAM_HEIGHT-1
- RAM_WIDTH, 16, data width and address width (RAM address port is RAM_WIDTH bits)
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle command strobe, sampled only in IDLE
- base  in  RAM_WIDTH  first address of burst, sampled with start
- len  in  RAM_WIDTH  number of words in burst, sampled with start
- ram_a  out  RAM_WIDTH  RAM address
- ram_we  out  1  RAM write enable, constant 0
- ram_do  in  RAM_WIDTH  RAM combinational read data for ram_a
- m_data  out  RAM_WIDTH  output word (registered)
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accept
- m_last  out  1  qualifies final beat of burst
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last beat accepted
- err  out  1  one-cycle pulse when a start is rejected

## Operation
- States: IDLE, READ, DRAIN. Counters: addr (current RAM address), remaining (words not yet fetched).
- IDLE: start with len≠0 and base<RAM_HEIGHT → latch addr=base, remaining=len, busy=1, go READ. start with len=0 → done pulse next cycle, no beats, stay IDLE. start with base≥RAM_HEIGHT → err pulse, stay IDLE.
- READ: ram_a=addr. Output register loads ram_do when !m_valid or (m_valid && m_ready). Each load: addr advances, remaining decrements; load with remaining==1 sets m_last, goes DRAIN.
- DRAIN: hold final beat until m_ready; on acceptance m_valid=0, busy=0, done=1, go IDLE.
- Backpressure: m_valid && !m_ready freezes m_data, m_last, addr, remaining; m_data is never changed while valid and unaccepted.
- start in READ/DRAIN ignored (no err).
- Address end: without wrap macro, burst is truncated at RAM_HEIGHT-1 (that beat carries m_last; remaining discarded).
- ram_a in IDLE/DRAIN holds the last driven address; ram_we=0 always.

## Timing
- Reset values: ram_a=0, ram_we=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0, err=0; state IDLE.
- start at edge N → busy=1 and ram_a=base after N; first m_valid=1 after edge N+1 (latency 2 cycles).
- Throughput one word per cycle with m_ready held high; burst of L words ends with done pulse the cycle after the last beat's acceptance edge.
- rst mid-burst: all outputs to reset values on next edge, pending beat discarded, no done.

## Configuration
- RAM_BURST_READER_WRAP_EN defined: addr increments modulo RAM_HEIGHT (RAM_HEIGHT-1 → 0), len up to RAM_HEIGHT permitted; circular delay-line reads. len>RAM_HEIGHT → err, rejected.
- Undefined: no wrap; truncation at RAM_HEIGHT-1 as above.

## Structure
- Package ram_burst_reader_pkg: state typedef (IDLE/READ/DRAIN), default RAM_HEIGHT/RAM_WIDTH constants.
- One sub-module: stream_out_reg — single-entry registered output stage (data, last, valid/ready, load enable back to controller).

## Test plan
- Reset then start base=10, len=4, m_ready=1, RAM[i]=i*3 → beats 30,33,36,39 on consecutive cycles, m_last on 39, done next cycle, first m_valid 2 cycles after start.
- Same burst, m_ready low for 3 cycles on beat 2 → m_data holds 33 stable, no beats dropped or repeated.
- start base=277, len=4: without macro → beats RAM[277],RAM[278], m_last on 278; with macro → RAM[277],RAM[278],RAM[0],RAM[1].
- start len=0 → done one cycle later, m_valid never asserts; start base=300 → err pulse, busy stays 0.
- rst asserted on 2nd beat of base=0,len=8 → all outputs zero next cycle; new start base=5,len=1 then completes normally.
- start pulsed again during READ → ignored, original burst completes unchanged, err stays 0.

Source files
------------

// File: rtl/ram_burst_reader_pkg.sv
// Shared types and default geometry for the RAM burst reader.
// The optional circular-address mode is selected by RAM_BURST_READER_WRAP_EN.
package ram_burst_reader_pkg;

    localparam int RAM_HEIGHT_DEFAULT = 279;
    localparam int RAM_WIDTH_DEFAULT  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// RAM port and output stream bundle between the burst reader, the RAM and the MAC datapath.
// Handshake: a beat transfers on a posedge where m_valid && m_ready; while m_valid is high and
// m_ready is low, m_data and m_last stay frozen and m_valid never drops.
interface ram_burst_reader_if #(
    parameter int WIDTH = 16
) ();

    logic [WIDTH-1:0] ram_a;
    logic             ram_we;
    logic [WIDTH-1:0] ram_do;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (
        output ram_a, ram_we, m_data, m_valid, m_last,
        input  ram_do, m_ready
    );

    modport slave (
        input  ram_a, ram_we, m_data, m_valid, m_last,
        output ram_do, m_ready
    );

endinterface

// File: rtl/ram_burst_reader_stream_out_reg.sv
// Single-entry registered output stage: captures a word when the controller offers one and
// the slot is free or being drained this cycle; load tells the controller the word was taken.
module stream_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             load,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready
);

    assign load = in_valid && (!m_valid || m_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_data  <= in_data;
            m_last  <= in_last;
            m_valid <= 1'b1;
        end else if (m_valid && m_ready) begin
            // Data is left in place; only the qualifiers drop.
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Walks a contiguous RAM address range and streams each word out with a last-beat marker.
// Define RAM_BURST_READER_WRAP_EN for circular addressing (RAM_HEIGHT-1 wraps to 0).
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int RAM_HEIGHT = RAM_HEIGHT_DEFAULT,
    parameter int RAM_WIDTH  = RAM_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [RAM_WIDTH-1:0] base,
    input  logic [RAM_WIDTH-1:0] len,
    ram_burst_reader_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output state_t               dbg_state
);

    localparam logic [RAM_WIDTH-1:0] LAST_ADDR = RAM_WIDTH'(RAM_HEIGHT - 1);
    localparam logic [RAM_WIDTH-1:0] HEIGHT    = RAM_WIDTH'(RAM_HEIGHT);
    localparam logic [RAM_WIDTH-1:0] ONE       = RAM_WIDTH'(1);

    state_t               state;
    logic [RAM_WIDTH-1:0] addr;
    logic [RAM_WIDTH-1:0] remaining;
    logic [RAM_WIDTH-1:0] next_addr;
    logic                 last_fetch;
    logic                 start_ok;
    logic                 load;
    logic                 accept;
    logic [RAM_WIDTH-1:0] s_data;
    logic                 s_valid;
    logic                 s_last;

`ifdef RAM_BURST_READER_WRAP_EN
    assign last_fetch = (remaining == ONE);
    assign next_addr  = (addr == LAST_ADDR) ? '0 : addr + ONE;
    assign start_ok   = (base < HEIGHT) && (len <= HEIGHT);
`else
    // The top word ends the burst early; whatever is left of len is dropped.
    assign last_fetch = (remaining == ONE) || (addr == LAST_ADDR);
    assign next_addr  = addr + ONE;
    assign start_ok   = (base < HEIGHT);
`endif

    stream_out_reg #(.WIDTH(RAM_WIDTH)) u_out (
        .clk     (clk),
        .rst     (rst),
        .in_valid(state == READ),
        .in_data (bus.ram_do),
        .in_last (last_fetch),
        .load    (load),
        .m_data  (s_data),
        .m_valid (s_valid),
        .m_last  (s_last),
        .m_ready (bus.m_ready)
    );

    assign accept      = s_valid && bus.m_ready;
    assign bus.m_data  = s_data;
    assign bus.m_valid = s_valid;
    assign bus.m_last  = s_last;
    assign bus.ram_a   = addr;
    assign bus.ram_we  = 1'b0;
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else if (start_ok) begin
                            addr      <= base;
                            remaining <= len;
                            busy      <= 1'b1;
                            state     <= READ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (load) begin
                        remaining <= remaining - ONE;
                        // ram_a keeps the final fetched address through DRAIN and IDLE.
                        if (last_fetch) state <= DRAIN;
                        else            addr  <= next_addr;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
